// File: rtl/arb_pkg.sv
// Package shared by the round-robin arbiter slice.
//   state_t    : arbiter FSM states (IDLE, BUSY)
//   PRIO_FIXED : policy code, lowest set request index always wins
//   PRIO_RR    : policy code, round-robin starting at the rotating pointer
package arb_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   localparam int PRIO_FIXED = 0;
   localparam int PRIO_RR    = 1;

endpackage

// File: rtl/rr_arbiter_if.sv
// Request/grant bundle between requesters and the arbiter.
//   req        : request vector, bit i = requester i
//   done       : current owner releases its grant
//   gnt_valid  : a grant is active
//   gnt_idx    : owner index, 0 when no grant
//   gnt_onehot : owner as a one-hot vector, 0 when no grant
//   timeout    : one-cycle pulse after a watchdog-forced release
// Handshake: there is no ready.  A requester holds its req bit until it sees
// its index granted (gnt_valid=1, gnt_idx=i).  It keeps the grant, with or
// without req, until it drives done=1 for one cycle.  The arbiter may also
// take the grant back after MAX_HOLD cycles and report that through timeout.
// All grant-side signals are registered.
interface rr_arbiter_if #(
   parameter int NUM_REQ = 8,
   parameter int IDX_W   = $clog2(NUM_REQ)
);

   logic [NUM_REQ-1:0] req;
   logic               done;
   logic               gnt_valid;
   logic [IDX_W-1:0]   gnt_idx;
   logic [NUM_REQ-1:0] gnt_onehot;
   logic               timeout;

   modport master (
      output req, done,
      input  gnt_valid, gnt_idx, gnt_onehot, timeout
   );

   modport slave (
      input  req, done,
      output gnt_valid, gnt_idx, gnt_onehot, timeout
   );

endinterface

// File: rtl/rr_arbiter_prio_find.sv
// Combinational lowest-set-bit finder.
//   vec   : input vector
//   found : at least one bit of vec is set
//   idx   : index of the lowest set bit (0 when found=0)
module prio_find #(
   parameter int W  = 8,
   parameter int IW = $clog2(W)
) (
   input  logic [W-1:0]  vec,
   output logic          found,
   output logic [IW-1:0] idx
);

   // Scan from the top so the last hit, the lowest set index, wins.
   always_comb begin
      found = |vec;
      idx   = '0;
      for (int i = W - 1; i >= 0; i--) begin
         if (vec[i]) idx = IW'(i);
      end
   end

endmodule

// File: rtl/rr_arbiter.sv
// Registered N-way request arbiter, fixed-priority or round-robin.
// A grant is held until the owner signals done or the hold watchdog fires.
// On release the arbiter re-arbitrates in the same cycle, so back-to-back
// grants have no idle bubble.
//   clk       : clock, rising edge
//   rst_n     : asynchronous active-low reset
//   bus       : request/grant bundle (slave side)
//   dbg_state : current FSM state, for observation only
module rr_arbiter
   import arb_pkg::*;
#(
   parameter int NUM_REQ   = 8,
   parameter int IDX_W     = $clog2(NUM_REQ),
   parameter int PRIO_MODE = PRIO_RR,
   parameter int MAX_HOLD  = 16,
   parameter int HOLD_W    = $clog2(MAX_HOLD + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   rr_arbiter_if.slave   bus,
   output state_t        dbg_state
);

   // MAX_HOLD=0 gives a zero-width counter; keep at least one bit.
   localparam int CNT_W = (HOLD_W < 1) ? 1 : HOLD_W;

   state_t             state, state_nxt;
   logic [IDX_W-1:0]   ptr, ptr_nxt;
   logic [CNT_W-1:0]   hold_cnt, hold_nxt;
   logic               valid_q, valid_nxt;
   logic [IDX_W-1:0]   idx_q, idx_nxt;
   logic [NUM_REQ-1:0] oh_q, oh_nxt;
   logic               tmo_q, tmo_nxt;

   logic [IDX_W-1:0]   rel_ptr, arb_ptr, win;
   logic [NUM_REQ-1:0] mask_ge, req_masked;
   logic               hi_found, lo_found;
   logic [IDX_W-1:0]   hi_idx, lo_idx;
   logic               any_req, wd_fire, release_now;

   // Pointer value after releasing the current owner.  In BUSY the search
   // must already start there, so the releasing owner ranks last.
   assign rel_ptr = (idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : idx_q + IDX_W'(1);
   assign arb_ptr = (state == BUSY) ? rel_ptr : ptr;

   always_comb begin
      mask_ge = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         mask_ge[i] = (IDX_W'(i) >= arb_ptr);
      end
   end

   assign req_masked = bus.req & mask_ge;
   assign any_req    = |bus.req;

   prio_find #(.W(NUM_REQ), .IW(IDX_W)) u_find_hi (
      .vec   (req_masked),
      .found (hi_found),
      .idx   (hi_idx)
   );

   prio_find #(.W(NUM_REQ), .IW(IDX_W)) u_find_lo (
      .vec   (bus.req),
      .found (lo_found),
      .idx   (lo_idx)
   );

   // Fall back to the unmasked search when nothing is at or above the pointer.
   assign win = (PRIO_MODE == PRIO_FIXED) ? lo_idx :
                (hi_found ? hi_idx : lo_idx);

   // done has priority: a simultaneous done and watchdog is a normal release.
   assign wd_fire     = (MAX_HOLD != 0) && !bus.done &&
                        (hold_cnt == CNT_W'(MAX_HOLD - 1));
   assign release_now = bus.done || wd_fire;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         ptr      <= '0;
         hold_cnt <= '0;
         valid_q  <= 1'b0;
         idx_q    <= '0;
         oh_q     <= '0;
         tmo_q    <= 1'b0;
      end else begin
         state    <= state_nxt;
         ptr      <= ptr_nxt;
         hold_cnt <= hold_nxt;
         valid_q  <= valid_nxt;
         idx_q    <= idx_nxt;
         oh_q     <= oh_nxt;
         tmo_q    <= tmo_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      ptr_nxt   = ptr;
      hold_nxt  = hold_cnt;
      valid_nxt = valid_q;
      idx_nxt   = idx_q;
      oh_nxt    = oh_q;
      tmo_nxt   = 1'b0;
      case (state)
         IDLE: begin
            if (any_req) begin
               state_nxt = BUSY;
               hold_nxt  = '0;
               valid_nxt = 1'b1;
               idx_nxt   = win;
               oh_nxt    = NUM_REQ'(1) << win;
            end
         end
         BUSY: begin
            if (release_now) begin
               ptr_nxt  = rel_ptr;
               hold_nxt = '0;
               tmo_nxt  = wd_fire;
               if (any_req) begin
                  idx_nxt = win;
                  oh_nxt  = NUM_REQ'(1) << win;
               end else begin
                  state_nxt = IDLE;
                  valid_nxt = 1'b0;
                  idx_nxt   = '0;
                  oh_nxt    = '0;
               end
            end else if (hold_cnt != '1) begin
               hold_nxt = hold_cnt + CNT_W'(1);
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign bus.gnt_valid  = valid_q;
   assign bus.gnt_idx    = idx_q;
   assign bus.gnt_onehot = oh_q;
   assign bus.timeout    = tmo_q;
   assign dbg_state      = state;

endmodule
